// File: rtl/ifu_pkg.sv
// Shared types for the instruction-fetch unit: FSM state encoding and AXI response codes.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        HOLD
    } ifu_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ifu_axi_fetch.sv
// Instruction-fetch unit: one outstanding AXI4-Lite read per PC, handed to decode via valid/ready.
// Misaligned PCs, error responses and response timeouts are reported through fetch_err.
module ifu_axi_fetch
    import ifu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    ifu_state_e        stateQ, stateD;
    logic [ADDR_W-1:0] pcQ, pcD;
    logic [ADDR_W-1:0] araddrQ, araddrD;
    logic [DATA_W-1:0] instQ, instD;
    logic              errQ, errD;
    logic [CntW-1:0]   cntQ, cntD;
    logic              timeoutHit;

    // Fires on the TIMEOUT-th RESP cycle; an rvalid in that same cycle takes priority.
    assign timeoutHit = (TIMEOUT != 0) && (cntQ == CntW'(TIMEOUT - 1));

    always_comb begin
        stateD  = stateQ;
        pcD     = pcQ;
        araddrD = araddrQ;
        instD   = instQ;
        errD    = errQ;
        cntD    = cntQ;
        case (stateQ)
            IDLE: begin
                if (s_valid) begin
                    pcD   = pc;
                    instD = '0;
                    if (pc[1:0] != 2'b00) begin
                        errD   = 1'b1;
                        stateD = HOLD;
                    end else begin
                        errD    = 1'b0;
                        araddrD = pc;
                        stateD  = ADDR;
                    end
                end
            end
            ADDR: begin
                if (arready) begin
                    stateD = RESP;
                end
            end
            RESP: begin
                if (rvalid) begin
                    instD  = rdata;
                    errD   = (rresp != RESP_OKAY);
                    cntD   = '0;
                    stateD = HOLD;
                end else if (timeoutHit) begin
                    instD  = '0;
                    errD   = 1'b1;
                    cntD   = '0;
                    stateD = HOLD;
                end else if (cntQ != '1) begin
                    cntD = cntQ + 1'b1;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    stateD = IDLE;
                end
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ  <= IDLE;
            pcQ     <= '0;
            araddrQ <= '0;
            instQ   <= '0;
            errQ    <= 1'b0;
            cntQ    <= '0;
        end else begin
            stateQ  <= stateD;
            pcQ     <= pcD;
            araddrQ <= araddrD;
            instQ   <= instD;
            errQ    <= errD;
            cntQ    <= cntD;
        end
    end

    assign s_ready   = (stateQ == IDLE);
    assign m_valid   = (stateQ == HOLD);
    assign arvalid   = (stateQ == ADDR);
    assign rready    = (stateQ == RESP);
    assign araddr    = araddrQ;
    assign inst      = instQ;
    assign inst_pc   = pcQ;
    assign fetch_err = errQ;

    arNoWithdraw: assert property (@(posedge clk) disable iff (rst)
        arvalid && !arready |=> arvalid && $stable(araddr));

    rOnlyInResp: assert property (@(posedge clk) disable iff (rst)
        rvalid |-> stateQ == RESP);

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch: expected results are queued per request and
// checked by an independent monitor whenever decode accepts an instruction.
module tb_ifu_axi_fetch;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    ifu_axi_fetch #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (pc),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .inst     (inst),
        .inst_pc  (inst_pc),
        .fetch_err(fetch_err),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   arHs = 0;
    int   arSeen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: AR bookkeeping and scoreboard pops on each decode acceptance.
    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid) arSeen++;
            if (arvalid && arready) arHs++;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_inst", inst, e.inst);
                    check("sb_inst_pc", inst_pc, e.pc);
                    check("sb_fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic doFetch(input logic [31:0] addr, input int arDly, input int rDly,
                           input logic [1:0] resp, input logic [31:0] data, input int mDly,
                           input bit noResp, input logic [31:0] expInst, input bit expErr,
                           input int expLat);
        int hs0;
        int seen0;
        int lat;
        int respCyc;
        bit mis;
        mis = (addr[1:0] != 2'b00);
        sb.push_back(exp_t'{expInst, addr, expErr});
        hs0 = arHs;
        seen0 = arSeen;
        check("s_ready_idle", s_ready, 1);
        pc = addr;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        pc = 32'hFFFF_FFFF;
        lat = 1;
        if (!mis) begin
            check("arvalid_up", arvalid, 1);
            check("araddr", araddr, addr);
            repeat (arDly) begin
                @(posedge clk); #1;
                lat++;
                check("ar_hold_valid", arvalid, 1);
                check("ar_hold_addr", araddr, addr);
            end
            arready = 1'b1;
            @(posedge clk); #1;
            arready = 1'b0;
            lat++;
            check("arvalid_drop", arvalid, 0);
            check("rready_up", rready, 1);
            if (noResp) begin
                respCyc = 0;
                while (rready && respCyc < 40) begin
                    respCyc++;
                    @(posedge clk); #1;
                    lat++;
                end
                check("timeout_cycles", respCyc, TO);
            end else begin
                repeat (rDly) begin
                    @(posedge clk); #1;
                    lat++;
                end
                rvalid = 1'b1;
                rdata = data;
                rresp = resp;
                @(posedge clk); #1;
                rvalid = 1'b0;
                rdata = '0;
                rresp = 2'b00;
                lat++;
            end
        end
        check("m_valid_up", m_valid, 1);
        check("rready_down", rready, 0);
        if (expLat > 0) check("latency", lat, expLat);
        repeat (mDly) begin
            @(posedge clk); #1;
            check("hold_valid", m_valid, 1);
            check("hold_inst", inst, expInst);
            check("hold_pc", inst_pc, addr);
            check("hold_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("s_ready_back", s_ready, 1);
        check("m_valid_down", m_valid, 0);
        check("ar_handshakes", arHs - hs0, mis ? 0 : 1);
        if (mis) check("no_arvalid", arSeen - seen0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pc = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        arready = 1'b0;
        rdata = '0;
        rresp = 2'b00;
        rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1);
        check("rst_m_valid", m_valid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_fetch_err", fetch_err, 0);
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_araddr", araddr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // zero-wait fetch
        doFetch(32'h8000_0000, 0, 0, 2'b00, 32'h0000_0413, 0, 0, 32'h0000_0413, 0, 3);
        // backpressure on AR, R and decode
        doFetch(32'h8000_0010, 4, 2, 2'b00, 32'h00A0_0093, 5, 0, 32'h00A0_0093, 0, 9);
        // SLVERR and DECERR responses
        doFetch(32'h8000_0020, 0, 0, 2'b10, 32'hDEAD_BEEF, 1, 0, 32'hDEAD_BEEF, 1, 3);
        doFetch(32'h8000_0024, 1, 1, 2'b11, 32'h1234_5678, 0, 0, 32'h1234_5678, 1, 5);
        // misaligned PCs never touch the bus
        doFetch(32'h8000_0002, 0, 0, 2'b00, 32'h0, 2, 0, 32'h0, 1, 1);
        doFetch(32'h8000_0001, 0, 0, 2'b00, 32'h0, 0, 0, 32'h0, 1, 1);
        // timeout with no beat, then beat on the last allowed cycle
        doFetch(32'h8000_0030, 0, 0, 2'b00, 32'h0, 1, 1, 32'h0, 1, 10);
        doFetch(32'h8000_0034, 0, 7, 2'b00, 32'hCAFE_0013, 0, 0, 32'hCAFE_0013, 0, 10);

        // reset while waiting for R
        pc = 32'h8000_0040;
        s_valid = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        check("pre_rst_rready", rready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_rready", rready, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_arvalid", arvalid, 0);
        doFetch(32'h8000_0004, 0, 0, 2'b00, 32'h0010_0073, 0, 0, 32'h0010_0073, 0, 3);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
